// File: rtl/scale_up_2x_nn_pkg.sv
// Shared state encoding and sizing helpers for the 2x nearest-neighbour upscaler.
package scale_up_2x_nn_pkg;

  typedef enum logic {
    S_LIVE   = 1'b0,
    S_REPEAT = 1'b1
  } state_t;

  localparam int COORD_W = 11;

  function automatic int beats_of(input int frame_width);
    return frame_width / 2;
  endfunction

  function automatic int addr_w_of(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/scale_up_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port.
module scale_up_line_buf #(
  parameter int DEPTH  = 270,
  parameter int WIDTH  = 48,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the array or read register so the tools can map them onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scale_up_2x_nn.sv
// 2PPC nearest-neighbour 2x upscaler: duplicates pixels horizontally, replays each line from a buffer.
module scale_up_2x_nn
  import scale_up_2x_nn_pkg::*;
#(
  parameter int P_DEPTH        = 8,
  parameter int IN_FRAME_WIDTH = 540
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COORD_W-1:0]   in_x,
  input  logic [COORD_W-1:0]   in_y,
  input  logic [2*P_DEPTH-1:0] in_red,
  input  logic [2*P_DEPTH-1:0] in_green,
  input  logic [2*P_DEPTH-1:0] in_blue,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [COORD_W-1:0]   out_x,
  output logic [COORD_W-1:0]   out_y,
  output logic [2*P_DEPTH-1:0] out_red,
  output logic [2*P_DEPTH-1:0] out_green,
  output logic [2*P_DEPTH-1:0] out_blue,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int BEATS  = beats_of(IN_FRAME_WIDTH);
  localparam int LAST   = BEATS - 1;
  localparam int ADDR_W = addr_w_of(BEATS);
  localparam int CW     = 2 * P_DEPTH;
  localparam int PIX_W  = 6 * P_DEPTH;

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(LAST);
  localparam logic [ADDR_W:0]    RD_LAST = (ADDR_W + 1)'(LAST);
  localparam logic [ADDR_W:0]    RD_END  = (ADDR_W + 1)'(BEATS);

  state_t             state_q, state_d;
  logic               hold_valid_q;
  logic               phase_q;
  logic [PIX_W-1:0]   hold_pix_q;
  logic [9:0]         hold_bx_q;
  logic [COORD_W-1:0] hold_y_q;
  logic [9:0]         cap_y_q;
  logic               last_seen_q;
  logic               rd_pending_q;
  logic [ADDR_W:0]    rd_addr_q;
  logic [ADDR_W-1:0]  rd_bx_q;
  logic [PIX_W-1:0]   ram_dout;

  logic fire, fire0, fire1, accept, rd_issue, rd_load;
  logic unused_bits;

  assign unused_bits = in_y[COORD_W-1];

  assign fire  = hold_valid_q & out_ready;
  assign fire0 = fire & ~phase_q;
  assign fire1 = fire & phase_q;

  // Ready depends combinationally on out_ready so a live line keeps full rate;
  // once the line's last beat is held, no new line may start until the replay ends.
  assign in_ready = (state_q == S_LIVE) & (~hold_valid_q | (fire1 & ~last_seen_q));
  assign accept   = in_valid & in_ready;

  assign rd_issue = (state_q == S_REPEAT) & (rd_addr_q <= RD_LAST) &
                    ((~hold_valid_q & ~rd_pending_q) | fire0);
  assign rd_load  = (state_q == S_REPEAT) & rd_pending_q & (~hold_valid_q | fire1);

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LIVE:   if (fire1 & last_seen_q) state_d = S_REPEAT;
      S_REPEAT: if (fire1 & ~rd_pending_q & (rd_addr_q == RD_END)) state_d = S_LIVE;
      default:  state_d = S_LIVE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LIVE;
      hold_valid_q <= 1'b0;
      phase_q      <= 1'b0;
      hold_pix_q   <= '0;
      hold_bx_q    <= '0;
      hold_y_q     <= '0;
      cap_y_q      <= '0;
      last_seen_q  <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_bx_q      <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        hold_valid_q <= 1'b1;
        phase_q      <= 1'b0;
        hold_pix_q   <= {in_blue, in_green, in_red};
        hold_bx_q    <= in_x[9:0];
        hold_y_q     <= {in_y[9:0], 1'b0};
        cap_y_q      <= in_y[9:0];
        if (in_x == X_LAST) last_seen_q <= 1'b1;
      end else if (rd_load) begin
        hold_valid_q <= 1'b1;
        phase_q      <= 1'b0;
        hold_pix_q   <= ram_dout;
        hold_bx_q    <= 10'(rd_bx_q);
        hold_y_q     <= {cap_y_q, 1'b1};
      end else if (fire) begin
        phase_q <= ~phase_q;
        if (phase_q) hold_valid_q <= 1'b0;
      end

      if (state_q == S_REPEAT && state_d == S_LIVE) last_seen_q <= 1'b0;

      if (state_q == S_LIVE && state_d == S_REPEAT) begin
        rd_addr_q <= '0;
      end else if (rd_issue) begin
        rd_addr_q <= rd_addr_q + 1'b1;
        rd_bx_q   <= rd_addr_q[ADDR_W-1:0];
      end

      if (rd_issue)     rd_pending_q <= 1'b1;
      else if (rd_load) rd_pending_q <= 1'b0;
    end
  end

  scale_up_line_buf #(
    .DEPTH  (BEATS),
    .WIDTH  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (in_x[ADDR_W-1:0]),
    .wr_data ({in_blue, in_green, in_red}),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr_q[ADDR_W-1:0]),
    .rd_data (ram_dout)
  );

  logic [CW-1:0] hold_red, hold_green, hold_blue;
  assign {hold_blue, hold_green, hold_red} = hold_pix_q;

  // Phase 0 shows the even pixel twice, phase 1 the odd pixel twice.
  assign out_red   = phase_q ? {2{hold_red[CW-1:P_DEPTH]}}   : {2{hold_red[P_DEPTH-1:0]}};
  assign out_green = phase_q ? {2{hold_green[CW-1:P_DEPTH]}} : {2{hold_green[P_DEPTH-1:0]}};
  assign out_blue  = phase_q ? {2{hold_blue[CW-1:P_DEPTH]}}  : {2{hold_blue[P_DEPTH-1:0]}};
  assign out_x     = {hold_bx_q, phase_q};
  assign out_y     = hold_y_q;
  assign out_valid = hold_valid_q;

endmodule

// File: tb/tb_scale_up_2x_nn.sv
// Bench for scale_up_2x_nn: a narrow (width 4) and a full-width (540) instance against an NN-upscale model.
module tb_scale_up_2x_nn;

  localparam int W0 = 4;
  localparam int W1 = 540;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] in_x[2], in_y[2], out_x[2], out_y[2];
  logic [15:0] in_red[2], in_green[2], in_blue[2];
  logic [15:0] out_red[2], out_green[2], out_blue[2];
  logic        in_valid[2], in_ready[2], out_valid[2], out_ready[2];

  always #5 clk = ~clk;

  scale_up_2x_nn #(.P_DEPTH(8), .IN_FRAME_WIDTH(W0)) dut_narrow (
    .clk(clk), .rst_n(rst_n),
    .in_x(in_x[0]), .in_y(in_y[0]),
    .in_red(in_red[0]), .in_green(in_green[0]), .in_blue(in_blue[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_x(out_x[0]), .out_y(out_y[0]),
    .out_red(out_red[0]), .out_green(out_green[0]), .out_blue(out_blue[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  scale_up_2x_nn #(.P_DEPTH(8), .IN_FRAME_WIDTH(W1)) dut_wide (
    .clk(clk), .rst_n(rst_n),
    .in_x(in_x[1]), .in_y(in_y[1]),
    .in_red(in_red[1]), .in_green(in_green[1]), .in_blue(in_blue[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_x(out_x[1]), .out_y(out_y[1]),
    .out_red(out_red[1]), .out_green(out_green[1]), .out_blue(out_blue[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference: input beat {o,e} at (x,y) becomes (2x,2y+rep,{e,e}) then (2x+1,2y+rep,{o,o}).
  function automatic beat_t up(input beat_t ib, input bit odd, input bit rep);
    beat_t o;
    o.x = 11'(2 * int'(ib.x) + int'(odd));
    o.y = 11'(2 * int'(ib.y) + int'(rep));
    o.r = odd ? {2{ib.r[15:8]}} : {2{ib.r[7:0]}};
    o.g = odd ? {2{ib.g[15:8]}} : {2{ib.g[7:0]}};
    o.b = odd ? {2{ib.b[15:8]}} : {2{ib.b[7:0]}};
    return o;
  endfunction

  beat_t exp_q[2][$];
  beat_t line_q[2][$];
  bit    line_done[2]  = '{default: 1'b0};
  bit    prev_stall[2] = '{default: 1'b0};
  beat_t prev_out[2];
  int    acc_cnt[2]    = '{default: 0};
  int    fire_cnt[2]   = '{default: 0};
  int    last_x[2]     = '{W0 / 2 - 1, W1 / 2 - 1};
  beat_t obs_q[$];
  int    obs_cyc[$];
  int    acc_cyc[$];
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every output transfer is checked against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        exp_q[k].delete();
        line_q[k].delete();
        line_done[k]  = 1'b0;
        prev_stall[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        beat_t act, ib;
        act = '{x: out_x[k], y: out_y[k], r: out_red[k], g: out_green[k], b: out_blue[k]};
        if (prev_stall[k]) begin
          check($sformatf("stall_valid%0d", k), 70'(out_valid[k]), 70'd1);
          check($sformatf("stall_hold%0d", k), act, prev_out[k]);
        end
        if (in_valid[k] && line_done[k])
          check($sformatf("no_accept_in_repeat%0d", k), 70'(in_ready[k]), 70'd0);
        if (out_valid[k] && out_ready[k]) begin
          fire_cnt[k]++;
          if (k == 0) begin
            obs_q.push_back(act);
            obs_cyc.push_back(cyc);
          end
          if (exp_q[k].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL out_beat%0d: unexpected beat %h", k, act);
          end else begin
            check($sformatf("out_beat%0d", k), act, exp_q[k].pop_front());
          end
          if (line_done[k] && exp_q[k].size() == 0) line_done[k] = 1'b0;
        end
        if (in_valid[k] && in_ready[k]) begin
          ib = '{x: in_x[k], y: in_y[k], r: in_red[k], g: in_green[k], b: in_blue[k]};
          acc_cnt[k]++;
          if (k == 0) acc_cyc.push_back(cyc);
          line_q[k].push_back(ib);
          exp_q[k].push_back(up(ib, 1'b0, 1'b0));
          exp_q[k].push_back(up(ib, 1'b1, 1'b0));
          if (int'(in_x[k]) == last_x[k]) begin
            foreach (line_q[k][i]) begin
              exp_q[k].push_back(up(line_q[k][i], 1'b0, 1'b1));
              exp_q[k].push_back(up(line_q[k][i], 1'b1, 1'b1));
            end
            line_q[k].delete();
            line_done[k] = 1'b1;
          end
        end
        prev_stall[k] = out_valid[k] && !out_ready[k];
        prev_out[k]   = act;
      end
    end
  end

  // out_ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random 50 %.
  int or_mode = 0;
  initial begin
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (or_mode)
          1:       out_ready[k] = ~out_ready[k];
          2:       out_ready[k] = 1'($urandom_range(0, 1));
          default: out_ready[k] = 1'b1;
        endcase
      end
    end
  end

  task automatic send_beat(input int k, input int x, input int y,
                           input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                           input bit keep);
    bit done = 1'b0;
    int n = 0;
    in_x[k] = 11'(x);
    in_y[k] = 11'(y);
    in_red[k] = r;
    in_green[k] = g;
    in_blue[k] = b;
    in_valid[k] = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready[k]) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 20000) begin
        fail_now("send_beat");
        done = 1'b1;
      end
    end
    if (!keep) in_valid[k] = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    if (obs_q.size() < n) fail_now("wait_obs");
  endtask

  // Hand-computed expectation of the first stimulus line: red {11,10},{13,12} upscaled.
  task automatic check_line4(input int base, input int yy);
    logic [15:0] red_tbl[4];
    red_tbl = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    for (int i = 0; i < 8; i++) begin
      if (base + i >= obs_q.size()) fail_now("line4_missing");
      else check($sformatf("line4_beat%0d", i),
                 70'({obs_q[base+i].x, obs_q[base+i].y, obs_q[base+i].r}),
                 70'({11'(i % 4), 11'(2 * yy + i / 4), red_tbl[i % 4]}));
    end
  endtask

  task automatic send_line4(input int y, input bit keep_last);
    send_beat(0, 0, y, 16'h0B0A, 16'h2120, 16'h3130, 1'b1);
    send_beat(0, 1, y, 16'h0D0C, 16'h2322, 16'h3332, keep_last);
  endtask

  int base, abase, n;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_x[k] = '0;
      in_y[k] = '0;
      in_red[k] = '0;
      in_green[k] = '0;
      in_blue[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_out_valid%0d", k), 70'(out_valid[k]), 70'd0);
      check($sformatf("rst_out_beat%0d", k),
            {out_x[k], out_y[k], out_red[k], out_green[k], out_blue[k]}, 70'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 70'(in_ready[0]), 70'd1);

    // Single line, out_ready high, with an input gap after the first beat.
    base = obs_q.size();
    send_beat(0, 0, 0, 16'h0B0A, 16'h2120, 16'h3130, 1'b0);
    @(negedge clk);
    check("accept_latency", 70'(out_valid[0]), 70'd1);
    @(posedge clk);
    #1;
    send_beat(0, 1, 0, 16'h0D0C, 16'h2322, 16'h3332, 1'b0);
    wait_obs(base + 8, 200);
    check_line4(base, 0);
    if (obs_cyc.size() >= base + 8)
      check("replay_no_gaps", 70'(obs_cyc[base+7] - obs_cyc[base+4]), 70'd3);

    // Two lines with in_valid held high throughout.
    base = obs_q.size();
    abase = acc_cyc.size();
    send_line4(1, 1'b1);
    send_line4(2, 1'b0);
    wait_obs(base + 16, 300);
    if (acc_cyc.size() >= abase + 4) begin
      check("ready_every_2nd_a", 70'(acc_cyc[abase+1] - acc_cyc[abase]), 70'd2);
      check("ready_every_2nd_b", 70'(acc_cyc[abase+3] - acc_cyc[abase+2]), 70'd2);
      check("line_gap_covers_replay", 70'(acc_cyc[abase+2] - acc_cyc[abase+1] >= 6), 70'd1);
    end else fail_now("accept_log");

    // Same line with out_ready toggling.
    or_mode = 1;
    base = obs_q.size();
    send_line4(0, 1'b0);
    wait_obs(base + 8, 300);
    check_line4(base, 0);
    or_mode = 0;

    // Two-line frame with distinct green values.
    base = obs_q.size();
    send_beat(0, 0, 0, 16'h0000, 16'hAAAA, 16'h0000, 1'b1);
    send_beat(0, 1, 0, 16'h0000, 16'hAAAA, 16'h0000, 1'b1);
    send_beat(0, 0, 1, 16'h0000, 16'h5555, 16'h0000, 1'b1);
    send_beat(0, 1, 1, 16'h0000, 16'h5555, 16'h0000, 1'b0);
    wait_obs(base + 16, 300);
    for (int i = 0; i < 16 && base + i < obs_q.size(); i++)
      check($sformatf("frame_beat%0d", i), 70'({obs_q[base+i].y, obs_q[base+i].g}),
            70'({11'(i / 4), (i < 8) ? 16'hAAAA : 16'h5555}));

    // Reset after the first replayed beat, then a fresh line.
    base = obs_q.size();
    send_line4(3, 1'b0);
    wait_obs(base + 5, 200);
    if (obs_q.size() >= base + 5) check("pre_reset_replay_y", 70'(obs_q[base+4].y), 70'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 70'(out_valid[0]), 70'd0);
    check("async_reset_y", 70'(out_y[0]), 70'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ready", 70'(in_ready[0]), 70'd1);
    base = obs_q.size();
    send_line4(5, 1'b0);
    wait_obs(base + 8, 200);
    for (int i = 0; i < 8 && base + i < obs_q.size(); i++)
      check($sformatf("post_reset_beat%0d", i), 70'({obs_q[base+i].x, obs_q[base+i].y}),
            70'({11'(i % 4), 11'(10 + i / 4)}));
    check("narrow_drained", 70'(exp_q[0].size()), 70'd0);

    // Full-width random frame with random backpressure and input gaps.
    or_mode = 2;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < W1 / 2; x++) begin
        send_beat(1, x, y, 16'($urandom()), 16'($urandom()), 16'($urandom()),
                  $urandom_range(0, 3) != 0);
        if (!in_valid[1]) begin
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid[1] = 1'b0;
    n = 0;
    while (fire_cnt[1] < 4 * acc_cnt[1] && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wide_accepts", 70'(acc_cnt[1]), 70'(3 * W1 / 2));
    check("wide_out_is_4x", 70'(fire_cnt[1]), 70'(4 * acc_cnt[1]));
    check("wide_drained", 70'(exp_q[1].size()), 70'd0);
    or_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
